oc_event_unit: RTL and testbench

//  Compare-output/event stage fed by the 1024 Hz compare generator's ocr_match level.
//  - Turns each rising edge of ocr_match into a single-cycle event.
//  - Drives an AVR-style output-compare pin (off/toggle/clear/set).
//  - Counts compare matches.
//  - Raises a sticky interrupt request with acknowledge handshake and overrun flag.

---
 rtl/oc_event_unit.sv | 148 ++++++++++++++
 tb/tb_oc_event_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_event_unit.sv
// rtl/oc_event_unit.sv - compare-match event stage: edge detect, OC pin, match counter, irq/ovf
//
// Optional feature macro: OC_PULSE_EN (adds oc_pulse port, PULSE_LEN/PL_W parameters
// and the pulse-stretch FSM; absent from the default build).
//
// Ports:
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   ocr_match  in   1      compare-match level, synchronous to clk
//   enable     in   1      1 = events act on outputs/counters
//   mode       in   2      00 off, 01 toggle, 10 clear, 11 set oc_out on event
//   irq_ack    in   1      1-cycle strobe, clears irq and ovf
//   match_evt  out  1      1-cycle pulse per accepted match event
//   oc_out     out  1      output-compare pin
//   irq        out  1      sticky interrupt request
//   ovf        out  1      sticky: event arrived while irq already set
//   match_cnt  out  CNT_W  accepted event count, wraps
//   oc_pulse   out  1      stretched event pulse (OC_PULSE_EN only)
module oc_event_unit #(
  parameter int CNT_W = 16
`ifdef OC_PULSE_EN
  , parameter int PULSE_LEN = 1024
  , parameter int PL_W      = 11
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ocr_match,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             irq_ack,
  output logic             match_evt,
  output logic             oc_out,
  output logic             irq,
  output logic             ovf,
  output logic [CNT_W-1:0] match_cnt
`ifdef OC_PULSE_EN
  , output logic           oc_pulse
`endif
);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_SET    = 2'b11;

  logic match_d;
  logic match_edge;
  logic evt;

  // match_d resets to 0, so a level already high at reset release counts as an edge.
  assign match_edge = ocr_match & ~match_d;
  assign evt        = match_edge & enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_d   <= 1'b0;
      match_evt <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_d   <= ocr_match;
      match_evt <= evt;
      if (evt) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

  // Mode 00 disconnects the pin and wins over any event; other modes act only on evt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_out <= 1'b0;
    end else if (mode == MODE_OFF) begin
      oc_out <= 1'b0;
    end else if (evt) begin
      case (mode)
        MODE_TOGGLE: oc_out <= ~oc_out;
        MODE_CLEAR:  oc_out <= 1'b0;
        MODE_SET:    oc_out <= 1'b1;
        default:     oc_out <= 1'b0;
      endcase
    end
  end

  // An ack coinciding with a new event retires the old request but keeps the new one,
  // so evt has priority for irq while the ack still clears ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (evt) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
      if (irq_ack) begin
        ovf <= 1'b0;
      end else if (evt && irq) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef OC_PULSE_EN
  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_ACTIVE = 1'b1;
  localparam logic [PL_W-1:0] PL_RELOAD = PL_W'(PULSE_LEN - 1);

  logic [0:0]      pl_state;
  logic [PL_W-1:0] pl_cnt;

  // Loading PULSE_LEN-1 on the event edge gives exactly PULSE_LEN high cycles,
  // starting in the same cycle as match_evt; a retrigger simply reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl_state <= ST_IDLE;
      pl_cnt   <= '0;
    end else begin
      case (pl_state)
        ST_IDLE: begin
          if (evt) begin
            pl_state <= ST_ACTIVE;
            pl_cnt   <= PL_RELOAD;
          end
        end
        ST_ACTIVE: begin
          if (evt) begin
            pl_cnt <= PL_RELOAD;
          end else if (pl_cnt == '0) begin
            pl_state <= ST_IDLE;
          end else begin
            pl_cnt <= pl_cnt - PL_W'(1);
          end
        end
        default: begin
          pl_state <= ST_IDLE;
          pl_cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded straight from the state register so reset drops it without waiting for clk.
  assign oc_pulse = (pl_state == ST_ACTIVE);
`endif

endmodule

// File: tb/tb_oc_event_unit.sv
// tb/tb_oc_event_unit.sv - directed self-checking bench for oc_event_unit
module tb_oc_event_unit;

  logic       clk;
  logic       rst_n;
  logic       ocr_match;
  logic       enable;
  logic [1:0] mode;
  logic       irq_ack;
  logic       match_evt;
  logic       oc_out;
  logic       irq;
  logic       ovf;
  logic [3:0] match_cnt;
`ifdef OC_PULSE_EN
  logic       oc_pulse;
`endif

  int n_checks;
  int n_fail;

  oc_event_unit #(
    .CNT_W(4)
`ifdef OC_PULSE_EN
    , .PULSE_LEN(4)
    , .PL_W(3)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ocr_match (ocr_match),
    .enable    (enable),
    .mode      (mode),
    .irq_ack   (irq_ack),
    .match_evt (match_evt),
    .oc_out    (oc_out),
    .irq       (irq),
    .ovf       (ovf),
    .match_cnt (match_cnt)
`ifdef OC_PULSE_EN
    , .oc_pulse (oc_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // One rising edge of ocr_match followed by one low cycle.
  task automatic fire(input logic ack);
    ocr_match = 1'b1;
    irq_ack   = ack;
    cyc();
    ocr_match = 1'b0;
    irq_ack   = 1'b0;
    cyc();
  endtask

  int seq1 [12] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  int evts;
`ifdef OC_PULSE_EN
  int seq5 [12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int hi_cnt;
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    ocr_match = 1'b0;
    enable    = 1'b0;
    mode      = 2'b00;
    irq_ack   = 1'b0;
    cyc();
    check("rst_match_evt", match_evt, 0);
    check("rst_oc_out", oc_out, 0);
    check("rst_irq", irq, 0);
    check("rst_ovf", ovf, 0);
    check("rst_match_cnt", match_cnt, 0);
`ifdef OC_PULSE_EN
    check("rst_oc_pulse", oc_pulse, 0);
`endif

    // Test 1: toggle mode, long high levels give one event each.
    rst_n  = 1'b1;
    mode   = 2'b01;
    enable = 1'b1;
    cyc();
    evts = 0;
    for (int i = 0; i < 12; i++) begin
      ocr_match = seq1[i][0];
      cyc();
      evts += int'(match_evt);
      if (i == 0) check("t1_oc_out_first", oc_out, 1);
    end
    check("t1_evt_count", evts, 2);
    check("t1_oc_out_end", oc_out, 0);
    check("t1_match_cnt", match_cnt, 2);
    check("t1_irq", irq, 1);
    check("t1_ovf", ovf, 1);

    // Test 2: irq/ovf handshake.
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    check("t2_ack_irq", irq, 0);
    check("t2_ack_ovf", ovf, 0);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    check("t2_idle_ack_irq", irq, 0);
    fire(1'b0);
    check("t2_evt_irq", irq, 1);
    check("t2_evt_ovf", ovf, 0);
    fire(1'b0);
    check("t2_second_ovf", ovf, 1);
    fire(1'b1);
    check("t2_evt_ack_irq", irq, 1);
    check("t2_evt_ack_ovf", ovf, 0);
    check("t2_match_cnt", match_cnt, 5);

    // Test 3: counter wrap and modes.
    mode = 2'b01;
    do_reset();
    for (int i = 0; i < 17; i++) fire(1'b0);
    check("t3_wrap_cnt", match_cnt, 1);
    check("t3_toggle17", oc_out, 1);
    mode = 2'b10;
    fire(1'b0);
    check("t3_clear", oc_out, 0);
    mode = 2'b11;
    cyc();
    check("t3_mode_no_evt", oc_out, 0);
    fire(1'b0);
    check("t3_set", oc_out, 1);
    mode = 2'b00;
    cyc();
    check("t3_off", oc_out, 0);
    check("t3_cnt_after", match_cnt, 3);

    // Test 4: enable gating.
    mode   = 2'b01;
    enable = 1'b0;
    do_reset();
    ocr_match = 1'b1;
    cyc();
    check("t4_dis_evt", match_evt, 0);
    enable = 1'b1;
    cyc();
    check("t4_en_high_evt", match_evt, 0);
    cyc();
    check("t4_en_high_cnt", match_cnt, 0);
    ocr_match = 1'b0;
    cyc();
    ocr_match = 1'b1;
    cyc();
    check("t4_rise_evt", match_evt, 1);
    check("t4_rise_cnt", match_cnt, 1);
    ocr_match = 1'b0;
    cyc();
    enable    = 1'b0;
    ocr_match = 1'b1;
    cyc();
    check("t4_gated_evt", match_evt, 0);
    check("t4_gated_cnt", match_cnt, 1);
    check("t4_gated_oc", oc_out, 1);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    check("t4_dis_ack_irq", irq, 0);
    mode = 2'b00;
    cyc();
    check("t4_dis_off", oc_out, 0);

    // Level already high when reset releases: one event in the first cycle.
    ocr_match = 1'b1;
    enable    = 1'b1;
    mode      = 2'b01;
    do_reset();
    cyc();
    check("t4_post_rst_evt", match_evt, 1);
    check("t4_post_rst_cnt", match_cnt, 1);
    ocr_match = 1'b0;
    cyc();

`ifdef OC_PULSE_EN
    // Test 5: pulse stretch and retrigger.
    do_reset();
    hi_cnt    = 0;
    ocr_match = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      ocr_match = 1'b0;
      hi_cnt += int'(oc_pulse);
    end
    check("t5_single_len", hi_cnt, 4);
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      ocr_match = seq5[i][0];
      cyc();
      hi_cnt += int'(oc_pulse);
    end
    check("t5_retrig_len", hi_cnt, 6);
`endif

    // Test 6: async reset mid-activity.
    mode = 2'b11;
    do_reset();
    fire(1'b0);
    check("t6_pre_oc", oc_out, 1);
    check("t6_pre_irq", irq, 1);
    ocr_match = 1'b1;
    cyc();
    rst_n = 1'b0;
    #2;
    check("t6_async_evt", match_evt, 0);
    check("t6_async_oc", oc_out, 0);
    check("t6_async_irq", irq, 0);
    check("t6_async_cnt", match_cnt, 0);
`ifdef OC_PULSE_EN
    check("t6_async_pulse", oc_pulse, 0);
`endif
    ocr_match = 1'b0;
    cyc();
    rst_n = 1'b1;
    evts  = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      evts += int'(match_evt);
    end
    check("t6_no_spurious", evts, 0);
    check("t6_cnt_after", match_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
